// File: rtl/layer_seq_pkg.sv
// Shared types and helpers for the sequential fully-connected layer.
package layer_pkg;

    // Activation select; the unused encoding 2'b11 behaves as hard sigmoid.
    typedef enum logic [1:0] {
        ACT_SIGM = 2'b00,
        ACT_RELU = 2'b01,
        ACT_STEP = 2'b10
    } act_mode_e;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        ACT,
        DONE
    } layer_state_e;

    // Saturate v into the closed range [lo, hi].
    function automatic int clamp(input int v, input int lo, input int hi);
        if (v < lo) begin
            return lo;
        end else if (v > hi) begin
            return hi;
        end
        return v;
    endfunction

endpackage

// File: rtl/layer_seq_if.sv
// Operand/result handshake bundle for layer_seq.
interface layer_seq_if #(
    parameter int LENGHT_I = 4,
    parameter int LENGHT_O = 2,
    parameter int WIDTH_I  = 1,
    parameter int WIDTH_W  = 9,
    parameter int WIDTH_O  = 10
);
    logic                                        in_valid;
    logic                                        in_ready;
    logic [LENGHT_I-1:0][WIDTH_I-1:0]            in;
    logic [LENGHT_I*LENGHT_O-1:0][WIDTH_W-1:0]   w_i;
    logic [LENGHT_O-1:0][WIDTH_W-1:0]            b_i;
    logic [1:0]                                  mode;
    logic                                        out_valid;
    logic                                        out_ready;
    logic [LENGHT_O-1:0][WIDTH_O-1:0]            out;

    modport master (
        output in_valid, in, w_i, b_i, mode, out_ready,
        input  in_ready, out_valid, out
    );

    modport slave (
        input  in_valid, in, w_i, b_i, mode, out_ready,
        output in_ready, out_valid, out
    );
endinterface

// File: rtl/layer_seq_neuron_mac.sv
// One neuron: bias-loaded accumulator, serial MAC step, activation and
// registered output.
module neuron_mac
    import layer_pkg::*;
#(
    parameter int WIDTH_I    = 1,
    parameter int WIDTH_W    = 9,
    parameter int WIDTH_ACC  = 13,
    parameter int WIDTH_O    = 10,
    parameter int RANGE_SIGM = 1000,
    parameter int SIG_SHIFT  = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [WIDTH_W-1:0] bias,
    input  logic               step,
    input  logic [WIDTH_W-1:0] weight,
    input  logic [WIDTH_I-1:0] x,
    input  logic               act,
    input  logic [1:0]         mode,
    output logic [WIDTH_O-1:0] out
);
    logic signed [WIDTH_ACC-1:0] acc_reg;
    logic signed [WIDTH_ACC-1:0] bias_ext;
    logic signed [WIDTH_ACC-1:0] w_ext;
    logic signed [WIDTH_ACC-1:0] x_ext;
    logic signed [WIDTH_ACC-1:0] prod;
    logic [WIDTH_O-1:0]          out_reg;
    int                          acc_int;
    int                          act_val;

    // Weight and bias are signed, inputs unsigned; widening both operands to
    // the accumulator width keeps the product exact.
    assign bias_ext = {{(WIDTH_ACC-WIDTH_W){bias[WIDTH_W-1]}}, bias};
    assign w_ext    = {{(WIDTH_ACC-WIDTH_W){weight[WIDTH_W-1]}}, weight};
    assign x_ext    = {{(WIDTH_ACC-WIDTH_I){1'b0}}, x};
    assign prod     = w_ext * x_ext;
    assign acc_int  = {{(32-WIDTH_ACC){acc_reg[WIDTH_ACC-1]}}, acc_reg};

    // Activation of the finished accumulator, selected by the captured mode.
    always_comb begin
        act_val = 0;
        case (mode)
            ACT_RELU: act_val = clamp(acc_int, 0, RANGE_SIGM-1);
            ACT_STEP: act_val = (acc_int > 0) ? RANGE_SIGM-1 : 0;
            default:  act_val = clamp(RANGE_SIGM/2 + (acc_int >>> SIG_SHIFT), 0, RANGE_SIGM-1);
        endcase
    end

    // Accumulator: bias load on accept, one product per ACC cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_reg <= '0;
        end else if (load) begin
            acc_reg <= bias_ext;
        end else if (step) begin
            acc_reg <= acc_reg + prod;
        end
    end

    // Output register; holds its value until the next activation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_reg <= '0;
        end else if (act) begin
            out_reg <= WIDTH_O'(act_val);
        end
    end

    assign out = out_reg;

endmodule

// File: rtl/layer_seq.sv
// Sequential fully-connected layer: one MAC per neuron, one input per clock,
// valid/ready on both sides.
module layer_seq
    import layer_pkg::*;
#(
    parameter int LENGHT_I   = 4,
    parameter int LENGHT_O   = 2,
    parameter int WIDTH_I    = 1,
    parameter int WIDTH_W    = 9,
    parameter int RANGE_SIGM = 1000,
    parameter int SIG_SHIFT  = 0
) (
    input  logic     clk,
    input  logic     rst,
    layer_seq_if.slave bus
);
    localparam int WIDTH_O   = $clog2(RANGE_SIGM);
    localparam int WIDTH_ACC = WIDTH_I + WIDTH_W + $clog2(LENGHT_I) + 1;
    localparam int IDX_W     = $clog2(LENGHT_I);

    layer_state_e                             state_reg, state_next;
    logic [IDX_W-1:0]                         idx_reg;
    logic [LENGHT_I-1:0][WIDTH_I-1:0]         in_reg;
    logic [LENGHT_O-1:0][LENGHT_I-1:0][WIDTH_W-1:0] w_reg;
    logic [1:0]                               mode_reg;
    logic                                     accept;
    logic                                     last_step;
    logic [WIDTH_O-1:0]                       out_w [LENGHT_O];

    assign accept    = (state_reg == IDLE) && bus.in_valid;
    assign last_step = (idx_reg == IDX_W'(LENGHT_I-1));

    // Next-state and handshake decode; ready/valid come purely from state.
    always_comb begin
        state_next    = state_reg;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state_reg)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) state_next = ACC;
            end
            ACC:  if (last_step) state_next = ACT;
            ACT:  state_next = DONE;
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Operand capture on accept and input index stepping during ACC.
    // The flat weight vector maps directly onto [neuron][input].
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_reg  <= '0;
            in_reg   <= '0;
            w_reg    <= '0;
            mode_reg <= '0;
        end else if (accept) begin
            idx_reg  <= '0;
            in_reg   <= bus.in;
            w_reg    <= bus.w_i;
            mode_reg <= bus.mode;
        end else if (state_reg == ACC) begin
            idx_reg  <= idx_reg + 1'b1;
        end
    end

    for (genvar gi = 0; gi < LENGHT_O; gi++) begin : g_neuron
        neuron_mac #(
            .WIDTH_I    (WIDTH_I),
            .WIDTH_W    (WIDTH_W),
            .WIDTH_ACC  (WIDTH_ACC),
            .WIDTH_O    (WIDTH_O),
            .RANGE_SIGM (RANGE_SIGM),
            .SIG_SHIFT  (SIG_SHIFT)
        ) u_mac (
            .clk    (clk),
            .rst    (rst),
            .load   (accept),
            .bias   (bus.b_i[gi]),
            .step   (state_reg == ACC),
            .weight (w_reg[gi][idx_reg]),
            .x      (in_reg[idx_reg]),
            .act    (state_reg == ACT),
            .mode   (mode_reg),
            .out    (out_w[gi])
        );
        assign bus.out[gi] = out_w[gi];
    end

endmodule

// File: tb/tb_layer_seq.sv
// Scoreboard bench for layer_seq with default parameters.
module tb_layer_seq;
    localparam int LI = 4;
    localparam int LO = 2;
    localparam int WI = 1;
    localparam int WW = 9;
    localparam int RS = 1000;
    localparam int WO = $clog2(RS);

    typedef logic [LI-1:0][WI-1:0]    in_t;
    typedef logic [LI*LO-1:0][WW-1:0] w_t;
    typedef logic [LO-1:0][WW-1:0]    b_t;
    typedef logic [LO-1:0][WO-1:0]    out_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   accept_cyc = 0;
    out_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    layer_seq_if #(.LENGHT_I(LI), .LENGHT_O(LO), .WIDTH_I(WI), .WIDTH_W(WW), .WIDTH_O(WO)) bus();

    layer_seq #(
        .LENGHT_I(LI), .LENGHT_O(LO), .WIDTH_I(WI), .WIDTH_W(WW),
        .RANGE_SIGM(RS), .SIG_SHIFT(0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Reference: accumulate in int, then activate and clamp.
    function automatic out_t model(input in_t i, input w_t w, input b_t b, input logic [1:0] m);
        out_t r;
        r = '0;
        for (int o = 0; o < LO; o++) begin
            int acc;
            int v;
            acc = int'($signed(b[o]));
            for (int k = 0; k < LI; k++) acc += int'($signed(w[o*LI+k])) * int'(i[k]);
            case (m)
                2'b01:   v = acc;
                2'b10:   v = (acc > 0) ? RS-1 : 0;
                default: v = RS/2 + acc;
            endcase
            if (v < 0) v = 0;
            if (v > RS-1) v = RS-1;
            r[o] = v[WO-1:0];
        end
        return r;
    endfunction

    // Output monitor: sampled mid-low-phase so same-negedge input changes are visible.
    always @(negedge clk) begin
        #2;
        if (!rst && bus.out_valid && bus.out_ready) begin
            out_t exp;
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: got out=%0d/%0d, none expected", bus.out[0], bus.out[1]);
            end else begin
                exp = sb.pop_front();
                $display("txn t=%0t out0=%0d out1=%0d exp0=%0d exp1=%0d", $time, bus.out[0], bus.out[1], exp[0], exp[1]);
                if (bus.out !== exp) begin
                    bad++;
                    $display("FAIL sb_out: got %0d/%0d want %0d/%0d", bus.out[0], bus.out[1], exp[0], exp[1]);
                end
            end
        end
    end

    task automatic send(input in_t i, input w_t w, input b_t b, input logic [1:0] m,
                        input out_t exp, input bit scramble);
        int n;
        n = 0;
        @(negedge clk);
        bus.in = i; bus.w_i = w; bus.b_i = b; bus.mode = m; bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            total++; bad++;
            $display("FAIL accept_timeout: in_ready=%0b after %0d cycles, need 1", bus.in_ready, n);
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        accept_cyc = cyc;
        sb.push_back(exp);
        @(negedge clk);
        bus.in_valid = 1'b0;
        if (scramble) begin
            bus.in = '0; bus.w_i = '0; bus.b_i = '0; bus.mode = 2'b00;
        end
    endtask

    // Scenario-1 operands.
    function automatic w_t w_scen1();
        w_t w;
        int wv[8] = '{1, 2, 3, 4, 5, 1, 2, 3};
        for (int k = 0; k < LI*LO; k++) w[k] = WW'(wv[k]);
        return w;
    endfunction

    task automatic test_reset();
        bus.in_valid = 1'b0; bus.in = '0; bus.w_i = '0; bus.b_i = '0;
        bus.mode = 2'b00; bus.out_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out !== '0) begin
            bad++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b out=%h want 1/0/0", bus.in_ready, bus.out_valid, bus.out);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: in_ready=%b out_valid=%b want 1/0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_relu();
        int n;
        send(4'b1110, w_scen1(), '0, 2'b01, {10'd6, 10'd9}, 1'b0);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n != 5) begin
            bad++;
            $display("FAIL relu_latency: got %0d cycles want 5", n);
        end
        @(negedge clk);
        total++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL relu_pulse: out_valid=%b in_ready=%b want 0/1", bus.out_valid, bus.in_ready);
        end
        total++;
        if (bus.out !== {10'd6, 10'd9}) begin
            bad++;
            $display("FAIL relu_hold: out=%0d/%0d want 9/6", bus.out[0], bus.out[1]);
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            total++; bad++;
            $display("FAIL %s_timeout: %0d results outstanding, want 0", name, sb.size());
        end
    endtask

    task automatic test_modes();
        send(4'b1110, w_scen1(), '0, 2'b00, {10'd506, 10'd509}, 1'b0);
        drain("sigm");
        send(4'b1110, w_scen1(), '0, 2'b10, {10'd999, 10'd999}, 1'b0);
        drain("step");
        send(4'b1110, w_scen1(), '0, 2'b11, {10'd506, 10'd509}, 1'b0);
        drain("mode11");
        send(4'b0000, w_scen1(), '0, 2'b10, {10'd0, 10'd0}, 1'b0);
        drain("step_zero");
    endtask

    task automatic test_saturation();
        w_t w;
        b_t b;
        for (int k = 0; k < LI*LO; k++) w[k] = 9'h100;
        for (int o = 0; o < LO; o++) b[o] = 9'h100;
        send(4'b1111, w, b, 2'b00, {10'd0, 10'd0}, 1'b0);
        drain("sat_neg");
        for (int k = 0; k < LI*LO; k++) w[k] = 9'h0FF;
        for (int o = 0; o < LO; o++) b[o] = 9'h0FF;
        send(4'b1111, w, b, 2'b01, {10'd999, 10'd999}, 1'b0);
        drain("sat_pos");
    endtask

    task automatic test_backpressure();
        int   n;
        int   errs;
        out_t held;
        bus.out_ready = 1'b0;
        send(4'b1110, w_scen1(), '0, 2'b01, {10'd6, 10'd9}, 1'b0);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        held = bus.out;
        errs = 0;
        for (int c = 0; c < 10; c++) begin
            if (c == 3) begin
                bus.in = 4'b1111; bus.w_i = '1; bus.b_i = '0; bus.mode = 2'b10; bus.in_valid = 1'b1;
            end
            if (c == 6) bus.in_valid = 1'b0;
            @(negedge clk);
            if (bus.out_valid !== 1'b1 || bus.out !== held || bus.in_ready !== 1'b0) errs++;
        end
        total++;
        if (errs != 0 || held !== {10'd6, 10'd9}) begin
            bad++;
            $display("FAIL bp_stall: %0d unstable cycles, held=%0d/%0d want 0 and 9/6", errs, held[0], held[1]);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        total++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b want 1/0", bus.in_ready, bus.out_valid);
        end
        errs = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) errs++;
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL bp_ignored: %0d spurious valid cycles want 0", errs);
        end
    endtask

    task automatic test_reset_mid_acc();
        in_t i;
        w_t  w;
        b_t  b;
        send(4'b1110, w_scen1(), '0, 2'b10, {10'd999, 10'd999}, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out !== '0) begin
            bad++;
            $display("FAIL rst_mid: in_ready=%b out_valid=%b out=%h want 1/0/0", bus.in_ready, bus.out_valid, bus.out);
        end
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        i = 4'b1011;
        for (int k = 0; k < LI*LO; k++) w[k] = WW'(k*7 - 20);
        b[0] = 9'd3; b[1] = 9'h1F0;
        send(i, w, b, 2'b00, model(i, w, b, 2'b00), 1'b0);
        drain("rst_recover");
    endtask

    task automatic test_operand_change();
        send(4'b1110, w_scen1(), '0, 2'b01, {10'd6, 10'd9}, 1'b1);
        drain("op_change");
    endtask

    task automatic test_back_to_back();
        int   a1;
        in_t  i;
        w_t   w;
        b_t   b;
        logic [1:0] m;
        bus.out_ready = 1'b1;
        send(4'b1110, w_scen1(), '0, 2'b01, {10'd6, 10'd9}, 1'b0);
        a1 = accept_cyc;
        send(4'b1110, w_scen1(), '0, 2'b00, {10'd506, 10'd509}, 1'b0);
        total++;
        if (accept_cyc - a1 != 7) begin
            bad++;
            $display("FAIL b2b_period: got %0d cycles want 7", accept_cyc - a1);
        end
        for (int r = 0; r < 6; r++) begin
            i = in_t'($urandom_range(0, 15));
            for (int k = 0; k < LI*LO; k++) w[k] = WW'($urandom_range(0, 511));
            for (int o = 0; o < LO; o++) b[o] = WW'($urandom_range(0, 511));
            m = 2'($urandom_range(0, 3));
            send(i, w, b, m, model(i, w, b, m), 1'b0);
        end
        drain("b2b");
    endtask

    initial begin
        test_reset();
        test_relu();
        test_modes();
        test_saturation();
        test_backpressure();
        test_reset_mid_acc();
        test_operand_change();
        test_back_to_back();
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/layer_seq.md
# layer_seq

Sequential, handshaked successor to the combinational fully-connected `layer`. It computes `LENGHT_O` neurons over `LENGHT_I` inputs using one MAC per neuron, stepping through the inputs one per clock. Compared with `layer`, it adds:
- multi-bit unsigned inputs;
- a per-neuron signed bias;
- a run-time-selectable activation (hard sigmoid, ReLU, step);
- valid/ready flow control on both sides.

It sits between successive layers of the inference pipeline.

## Interface
- `LENGHT_I`, 4: inputs per neuron (≥2).
- `LENGHT_O`, 2: neurons (outputs).
- `WIDTH_I`, 1: unsigned input width.
- `WIDTH_W`, 9: signed weight and bias width.
- `RANGE_SIGM`, 1000: activation output range, 0..RANGE_SIGM-1.
- `SIG_SHIFT`, 0: arithmetic right shift applied to the accumulator before the hard sigmoid.
- `WIDTH_O`, `$clog2(RANGE_SIGM)`: output width (derived, do not override).
- `WIDTH_ACC`, `WIDTH_I+WIDTH_W+$clog2(LENGHT_I)+1`: signed accumulator width (derived).

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operand set valid.
- `in_ready`  out  1  block can accept an operand set.
- `in`  in  `[LENGHT_I-1:0][WIDTH_I-1:0]`  unsigned inputs.
- `w_i`  in  `[LENGHT_I*LENGHT_O-1:0][WIDTH_W-1:0]`  signed weights; `w_i[o*LENGHT_I+i]` connects input i to neuron o.
- `b_i`  in  `[LENGHT_O-1:0][WIDTH_W-1:0]`  signed biases.
- `mode`  in  2  activation select: 00 hard sigmoid, 01 ReLU, 10 step, 11 = hard sigmoid.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts the result.
- `out`  out  `[LENGHT_O-1:0][WIDTH_O-1:0]`  activated outputs.

## Operation
- FSM states IDLE → ACC → ACT → DONE → IDLE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid` the block registers `in`, `w_i`, `b_i` and `mode`.
  - `acc[o]` ← sign-extended `b_i[o]`; index ← 0; go to ACC.
  - Operands may change freely after acceptance.
- **ACC**
  - Each cycle: `acc[o]` += signed(`w[o*LENGHT_I+idx]`) × zero-extended(`in[idx]`); idx++.
  - After idx = LENGHT_I-1 has been added, go to ACT.
  - The accumulator cannot overflow at `WIDTH_ACC`.
- **ACT**: one cycle; registers `out[o]` = f(`acc[o]`) using the captured mode; go to DONE.
- **DONE**
  - `out_valid`=1.
  - When `out_valid && out_ready`, go to IDLE.
- Activation functions:
  - Hard sigmoid: clamp(RANGE_SIGM/2 + (acc >>> SIG_SHIFT), 0, RANGE_SIGM-1).
  - ReLU: clamp(acc, 0, RANGE_SIGM-1).
  - Step: acc > 0 ? RANGE_SIGM-1 : 0; acc = 0 gives 0.
- `out` holds its last value after the output handshake until the next ACT.

## Timing
- Reset state:
  - FSM in IDLE, `in_ready`=1, `out_valid`=0, `out`=0, accumulators 0, index 0.
  - Reset takes effect asynchronously, including mid-ACC and mid-DONE; any in-flight result is discarded.
- `in_ready` is decoded combinationally from the state (high only in IDLE).
  - `in_valid` is ignored in every other state.
  - There is no back-to-back accept while DONE is pending.
- Latency: acceptance at edge E0 → `out_valid` rises after edge E(LENGHT_I+1).
  - Default parameters: 5 cycles.
- `out_valid` stays high while `out_ready`=0, and `out` is stable throughout.
- With `out_ready` held at 1, `out_valid` is a single-cycle pulse.
  - `in_ready` returns high in the cycle after the output handshake.
  - Throughput: one operand set per LENGHT_I+3 cycles.
- `in_valid` asserted in the same cycle as the output handshake is not accepted; it must be held until `in_ready`.

## Structure
- Package `layer_pkg` holds:
  - `act_mode_e` (ACT_SIGM=2'b00, ACT_RELU=2'b01, ACT_STEP=2'b10);
  - `layer_state_e` (IDLE, ACC, ACT, DONE);
  - a clamp helper function.
- The top level contains the FSM, the index counter, and operand capture.
- Sub-module `neuron_mac` (one accumulator, bias load, MAC step, activation and output register) is instantiated LENGHT_O times via generate.

## Test plan
All scenarios use default parameters and zero biases unless stated.
1. ReLU basic: `w_i[0..7]`=1,2,3,4,5,1,2,3; `in`={in0=0, in1=1, in2=1, in3=1}; `mode`=01 → `out[0]`=9, `out[1]`=6; `out_valid` rises 5 cycles after acceptance.
2. Same operands with `mode`=00 → `out`=509/506; with `mode`=10 → 999/999.
3. Negative and saturation:
   - all weights -256, biases -256, all inputs 1, hard sigmoid → acc=-1280 → `out`=0/0;
   - all weights 255, biases 255, ReLU → `out`=999/999.
4. Backpressure: hold `out_ready`=0 for 10 cycles → `out_valid` and `out` stable, `in_ready`=0, a second `in_valid` is ignored; release → `in_ready`=1 on the next cycle.
5. Reset mid-ACC (2 cycles after acceptance) → next cycle `in_ready`=1, `out_valid`=0, `out`=0; a new operand set then completes correctly.
6. Operands changed to 0 on the cycle after acceptance → result still equals that of the captured operands (scenario 1 values).
